// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: the colour-bar table
// and the sync polarity helper.
// The colour-bar stage is built only when VIDEO_TIMING_TEST_PATTERN_EN is defined.
// rgb_t is declared inside video_timing_gen, because a package type cannot
// take the per-instance COLOR_W parameter.
package video_timing_pkg;

  // Colour bars from left to right, one {r,g,b} on/off bit per channel:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  // Returns the pin level for a sync: pol when asserted, its inverse otherwise.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vt_axis_counter.sv
// One raster axis: a wrapping position counter plus decodes for the
// active region and the sync pulse. Region order along the axis is
// active, front porch, sync, back porch.
module vt_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync_asserted
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  // Position counter: clear wins over advance; wraps from TOTAL-1 to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

  assign wrap          = (count == LAST);
  assign active        = (count < ACT_END);
  assign sync_asserted = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and registered pixel output stage.
// Stage 0: counters and combinational decode (X, Y, PIX_REQ, LINE_START,
// FRAME_START). Stage 1: DE/sync registered while the renderer supplies
// PIX_*. Stage 2: registered VGA_* outputs, colour zeroed outside DE.
// Optional feature: VIDEO_TIMING_TEST_PATTERN_EN adds TEST_MODE colour bars.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic               CLK_PIX,
  input  logic               RESET_N,
  input  logic               ENABLE,
  input  logic               TEST_MODE,
  input  logic [COLOR_W-1:0] PIX_R,
  input  logic [COLOR_W-1:0] PIX_G,
  input  logic [COLOR_W-1:0] PIX_B,
  output logic [HW-1:0]      X,
  output logic [VW-1:0]      Y,
  output logic               PIX_REQ,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic               VGA_DE,
  output logic [COLOR_W-1:0] VGA_RED,
  output logic [COLOR_W-1:0] VGA_GREEN,
  output logic [COLOR_W-1:0] VGA_BLUE
);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  logic          run;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, h_act, h_sync;
  logic          v_wrap, v_act, v_sync;
  logic          unused_v_wrap;
  logic          de0, hs0, vs0;
  logic          de1, hs1, vs1;
  rgb_t          pix_sel;
  rgb_t          rgb_q;

  // run is ENABLE delayed one cycle; while low the counters sit at (0,0).
  always_ff @(posedge CLK_PIX or negedge RESET_N) begin
    if (!RESET_N) run <= 1'b0;
    else          run <= ENABLE;
  end

  vt_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h_axis (
    .clk(CLK_PIX), .rst_n(RESET_N), .advance(run), .clear(!run),
    .count(h_cnt), .wrap(h_wrap), .active(h_act), .sync_asserted(h_sync)
  );

  vt_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v_axis (
    .clk(CLK_PIX), .rst_n(RESET_N), .advance(run && h_wrap), .clear(!run),
    .count(v_cnt), .wrap(v_wrap), .active(v_act), .sync_asserted(v_sync)
  );

  // The vertical counter wraps on its own; nothing downstream needs the pulse.
  assign unused_v_wrap = v_wrap;

  // Stage 0 decode. Everything is gated by run so a stopped raster reads
  // (0,0) immediately and propagates blanking with inactive syncs.
  assign X           = run ? h_cnt : '0;
  assign Y           = run ? v_cnt : '0;
  assign de0         = run && h_act && v_act;
  assign hs0         = run && h_sync;
  assign vs0         = run && v_sync;
  assign PIX_REQ     = de0;
  assign LINE_START  = run && (h_cnt == '0);
  assign FRAME_START = LINE_START && (v_cnt == '0);

  // Stage 1: hold DE and sync decisions while the renderer presents PIX_*.
  always_ff @(posedge CLK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
    end else begin
      de1 <= de0;
      hs1 <= hs0;
      vs1 <= vs0;
    end
  end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  // Bar width rounds down; the last bar absorbs any remainder.
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);

  logic [HW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  logic [2:0]    bar1;

  // Bar sub-counter tracks the current h; it restarts wherever the next h
  // is 0 (line start or stopped raster) and stops advancing in the last bar.
  always_ff @(posedge CLK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!run || h_wrap) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_idx != 3'd7) begin
      if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + HW'(1);
      end
    end
  end

  // Carry the bar index alongside stage-1 DE.
  always_ff @(posedge CLK_PIX or negedge RESET_N) begin
    if (!RESET_N) bar1 <= '0;
    else          bar1 <= bar_idx;
  end

  // Pixel source: renderer data, or full-scale bar colours in test mode.
  always_comb begin
    pix_sel = {PIX_R, PIX_G, PIX_B};
    if (TEST_MODE) begin
      pix_sel.r = {COLOR_W{BAR_RGB[bar1][2]}};
      pix_sel.g = {COLOR_W{BAR_RGB[bar1][1]}};
      pix_sel.b = {COLOR_W{BAR_RGB[bar1][0]}};
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = TEST_MODE;

  // Pixel source: renderer data passes straight through.
  always_comb begin
    pix_sel = {PIX_R, PIX_G, PIX_B};
  end
`endif

  // Stage 2: registered outputs; colour is forced to 0 outside DE.
  always_ff @(posedge CLK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_DE    <= 1'b0;
      VGA_HSYNC <= sync_level(1'b0, HS_POL);
      VGA_VSYNC <= sync_level(1'b0, VS_POL);
      rgb_q     <= '0;
    end else begin
      VGA_DE    <= de1;
      VGA_HSYNC <= sync_level(hs1, HS_POL);
      VGA_VSYNC <= sync_level(vs1, VS_POL);
      rgb_q     <= de1 ? pix_sel : '0;
    end
  end

  assign VGA_RED   = rgb_q.r;
  assign VGA_GREEN = rgb_q.g;
  assign VGA_BLUE  = rgb_q.b;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small-raster instances (active-low and
// active-high syncs) checked cycle by cycle against a reference raster model
// with an expected-output queue, and one default-size instance for the
// colour-bar / pass-through path on the first line.
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       enable;
  logic       en_b;
  logic [7:0] pix_r;

  // small raster, active-low syncs
  logic [2:0] x_s, y_s;
  logic       req_s, ls_s, fs_s, hs_s, vs_s, de_s;
  logic [7:0] r_s, g_s, b_s;
  // small raster, active-high syncs
  logic [2:0] x_p, y_p;
  logic       req_p, ls_p, fs_p, hs_p, vs_p, de_p;
  logic [7:0] r_p, g_p, b_p;
  // default 640x480 raster
  logic [9:0] x_b, y_b;
  logic       req_b, ls_b, fs_b, hs_b, vs_b, de_b;
  logic [7:0] r_b, g_b, b_b;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8)
  ) dut (
    .CLK_PIX(clk), .RESET_N(rst_n), .ENABLE(enable), .TEST_MODE(1'b0),
    .PIX_R(pix_r), .PIX_G(8'hA5), .PIX_B(8'h3C),
    .X(x_s), .Y(y_s), .PIX_REQ(req_s), .LINE_START(ls_s), .FRAME_START(fs_s),
    .VGA_HSYNC(hs_s), .VGA_VSYNC(vs_s), .VGA_DE(de_s),
    .VGA_RED(r_s), .VGA_GREEN(g_s), .VGA_BLUE(b_s)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8)
  ) dut_pol (
    .CLK_PIX(clk), .RESET_N(rst_n), .ENABLE(enable), .TEST_MODE(1'b0),
    .PIX_R(pix_r), .PIX_G(8'hA5), .PIX_B(8'h3C),
    .X(x_p), .Y(y_p), .PIX_REQ(req_p), .LINE_START(ls_p), .FRAME_START(fs_p),
    .VGA_HSYNC(hs_p), .VGA_VSYNC(vs_p), .VGA_DE(de_p),
    .VGA_RED(r_p), .VGA_GREEN(g_p), .VGA_BLUE(b_p)
  );

  video_timing_gen dut_big (
    .CLK_PIX(clk), .RESET_N(rst_n), .ENABLE(en_b), .TEST_MODE(1'b1),
    .PIX_R(8'h12), .PIX_G(8'h34), .PIX_B(8'h56),
    .X(x_b), .Y(y_b), .PIX_REQ(req_b), .LINE_START(ls_b), .FRAME_START(fs_b),
    .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b), .VGA_DE(de_b),
    .VGA_RED(r_b), .VGA_GREEN(g_b), .VGA_BLUE(b_b)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  // {de, hsync asserted, vsync asserted, r, g, b} due two cycles later
  logic [26:0] exp_q[$];

  logic run_m;
  logic en_cur;
  int   hm, vm;
  int   prev_xm;
  int   cyc;
  int   last_fs;
  int   req_cnt;
  logic period_chk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_restart();
    run_m   = 1'b0;
    hm      = 0;
    vm      = 0;
    prev_xm = 0;
    en_cur  = enable;
    exp_q.delete();
    exp_q.push_back(27'd0);
    exp_q.push_back(27'd0);
  endtask

  function automatic logic [23:0] bar_color(input int xi);
    int idx;
    idx = xi / 80;
    if (idx > 7) idx = 7;
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // ---------------- driver: one small-raster cycle ----------------
  task automatic run_cycle(input logic en_next);
    int          xe, ye;
    logic        de_e, hs_a, vs_a;
    logic [26:0] e;
    @(posedge clk);
    #1;
    // reference raster advance, using run as it was before this edge
    if (run_m) begin
      if (hm == HT - 1) begin
        hm = 0;
        vm = (vm == VT - 1) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
    end else begin
      hm = 0;
      vm = 0;
    end
    run_m = en_cur;
    cyc++;
    xe   = run_m ? hm : 0;
    ye   = run_m ? vm : 0;
    de_e = run_m && (hm < HA) && (vm < VA);
    hs_a = run_m && (hm >= HA + HF) && (hm < HA + HF + HS);
    vs_a = run_m && (vm >= VA + VF) && (vm < VA + VF + VS);

    check("x", 32'(x_s), 32'(xe));
    check("y", 32'(y_s), 32'(ye));
    check("pix_req", 32'(req_s), 32'(de_e));
    check("line_start", 32'(ls_s), 32'(run_m && hm == 0));
    check("frame_start", 32'(fs_s), 32'(run_m && hm == 0 && vm == 0));

    check("queue_depth", 32'(exp_q.size()), 32'd2);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("vga_de", 32'(de_s), 32'(e[26]));
      check("vga_hsync", 32'(hs_s), 32'(!e[25]));
      check("vga_vsync", 32'(vs_s), 32'(!e[24]));
      check("vga_rgb", {8'h0, r_s, g_s, b_s}, {8'h0, e[23:0]});
      check("pol_de", 32'(de_p), 32'(e[26]));
      check("pol_hsync", 32'(hs_p), 32'(e[25]));
      check("pol_vsync", 32'(vs_p), 32'(e[24]));
    end
    exp_q.push_back({de_e, hs_a, vs_a, (de_e ? {8'(xe), 8'hA5, 8'h3C} : 24'h0)});

    if (fs_s) begin
      if (period_chk && last_fs >= 0) begin
        check("fs_period", 32'(cyc - last_fs), 32'(HT * VT));
        check("req_per_frame", 32'(req_cnt), 32'(HA * VA));
      end
      last_fs = cyc;
      req_cnt = 0;
    end
    if (req_s) req_cnt++;

    // renderer answers the previous cycle's request
    pix_r   = 8'(prev_xm);
    prev_xm = xe;
    en_cur  = en_next;
    enable  = en_next;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   drop_left;
    logic dropped;
    logic found;
    logic de_e;
    logic [23:0] rgb_e;

    rst_n      = 1'b0;
    enable     = 1'b1;
    en_b       = 1'b0;
    pix_r      = 8'h0;
    cyc        = 0;
    last_fs    = -1;
    req_cnt    = 0;
    period_chk = 1'b0;

    // reset held with ENABLE high
    repeat (3) @(posedge clk);
    #1;
    check("rst_de", 32'(de_s), 32'd0);
    check("rst_rgb", {8'h0, r_s, g_s, b_s}, 32'd0);
    check("rst_hsync", 32'(hs_s), 32'd1);
    check("rst_vsync", 32'(vs_s), 32'd1);
    check("rst_xy", 32'({x_s, y_s}), 32'd0);
    check("rst_pix_req", 32'(req_s), 32'd0);
    check("rst_pol_hsync", 32'(hs_p), 32'd0);
    check("rst_pol_vsync", 32'(vs_p), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    model_restart();

    // two full frames plus the start of a third
    period_chk = 1'b1;
    repeat (2 * HT * VT + 4) run_cycle(1'b1);
    period_chk = 1'b0;
    check("fs_seen", 32'(last_fs >= 0), 32'd1);

    // ENABLE low for 3 cycles starting at (h=2, v=1)
    drop_left = 0;
    dropped   = 1'b0;
    repeat (60) begin
      if (!dropped && run_m && hm == 1 && vm == 1) begin
        dropped   = 1'b1;
        drop_left = 3;
      end
      if (drop_left > 0) begin
        drop_left--;
        run_cycle(1'b0);
      end else begin
        run_cycle(1'b1);
      end
    end
    check("drop_done", 32'(dropped), 32'd1);

    // asynchronous reset in the middle of an active line
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      run_cycle(1'b1);
      if (run_m && hm == 2 && vm == 1) found = 1'b1;
    end
    check("async_target", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_de", 32'(de_s), 32'd0);
    check("arst_rgb", {8'h0, r_s, g_s, b_s}, 32'd0);
    check("arst_hsync", 32'(hs_s), 32'd1);
    check("arst_vsync", 32'(vs_s), 32'd1);
    check("arst_xy", 32'({x_s, y_s}), 32'd0);
    check("arst_pix_req", 32'(req_s), 32'd0);
    check("arst_frame_start", 32'(fs_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_restart();
    repeat (HT * VT + 5) run_cycle(1'b1);

    // default raster, first line: colour bars or pass-through
    rst_n = 1'b0;
    en_b  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 645; n++) begin
      @(posedge clk);
      #1;
      if (n == 0 || n == 80 || n == 639) begin
        check("big_x", 32'(x_b), 32'(n));
        check("big_y", 32'(y_b), 32'd0);
      end
      de_e = (n >= 2) && (n - 2 < 640);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
      rgb_e = de_e ? bar_color(n - 2) : 24'h0;
`else
      rgb_e = de_e ? 24'h123456 : 24'h0;
`endif
      check("big_de", 32'(de_b), 32'(de_e));
      check("big_rgb", {8'h0, r_b, g_b, b_b}, {8'h0, rgb_e});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
